match_engine_dispatcher: RTL
============================

// Module: match_engine_dispatcher
// PURPOSE
// Shares one parsed-packet stream among NENG vectormatch engines to scale rule-matching throughput.
// Sits between the packet parser (pnode stream) and a bank of match engines.
// Steers whole packets (sop..eop) to a ready engine, chosen round-robin.
// Merges the engines' 14-bit match results into one output queue, also round-robin.
// PARAMETERS
// NENG     4    number of match engines served (2..8)
// PNODE_W  142  packet beat width: [141:130] tag, [129] sop, [128] eop, [127:0] data
// RES_W    14   match result width per engine
// PORTS
// clock             in   1             single clock for the whole block
// reset             in   1             asynchronous, active-high
// in_data           in   PNODE_W       packet beat from parser
// in_valid          in   1             beat valid
// in_ready          out  1             beat accepted when in_valid && in_ready
// eng_data          out  PNODE_W       broadcast beat to all engines (= in_data)
// eng_valid         out  NENG          one-hot valid to the selected engine
// eng_ready         in   NENG          per-engine pnode_ready
// res_data          in   NENG*RES_W    engine i result at [i*RES_W+:RES_W] (show-ahead)
// res_valid         in   NENG          per-engine result available
// res_ack           out  NENG          one-cycle pop pulse to the granted engine
// match_data_out    out  RES_W         merged result
// match_data_valid  out  1             merged result valid
// match_data_ack    in   1             consumer pops merged result
// drop_count        out  16            count of dropped orphan beats; saturates at 16'hFFFF
// BEHAVIOUR
// Reset values: in_ready=0, eng_valid=0, res_ack=0, match_data_valid=0, match_data_out=0, drop_count=0.
// Reset state: FSM=IDLE, rr_in=0, rr_out=0.
// Dispatch FSM states: IDLE, LOCKED.
// - IDLE: candidate = first engine with eng_ready=1, searching from rr_in upward with wrap.
//   - in_ready = |eng_ready.
//   - sop beat accepted -> eng_valid[cand]=1 in the same cycle (combinational, zero latency).
//   - sel <= cand; rr_in <= cand+1 (mod NENG).
//   - Goes to LOCKED unless the same beat also has eop (single-beat packet stays IDLE).
// - IDLE, non-sop beat: in_ready=1, beat discarded, eng_valid=0, drop_count+1.
// - LOCKED: in_ready = eng_ready[sel]; eng_valid[sel] = in_valid.
//   - Accepted eop beat -> IDLE.
//   - A sop beat arriving while LOCKED is forwarded to sel as-is (the engine's capture resyncs).
//   - The lock is not broken.
// - eng_data = in_data always; eng_valid has at most one bit set.
// - No engine ready in IDLE: in_ready=0, the stream stalls; the rr pointer is unchanged.
// Result merge:
// - Output register; a load occurs when !match_data_valid || match_data_ack.
// - On load, grant g = first engine with res_valid=1, searching from rr_out upward with wrap.
//   - Same cycle: res_ack[g]=1.
//   - Next edge: match_data_out <= res_data[g], match_data_valid <= 1, rr_out <= g+1.
// - ack with no pending result clears match_data_valid.
// - ack with a pending result gives back-to-back output, 1 result/cycle.
// - Latency: res_valid rising -> match_data_valid = 1 cycle.
// - Result order across engines is not preserved; the consumer reorders by tag.
// - res_ack is never asserted for an engine with res_valid=0.
// Reset mid-packet: FSM returns to IDLE.
// - Remaining beats of that packet are counted as orphans until the next sop.
// - A pending output result is lost.
// STRUCTURE
// Shared package match_pkg: PNODE_W, RES_W, SOP_BIT=129, EOP_BIT=128, TAG_MSB=141, TAG_LSB=130.
// match_pkg typedefs: pnode_t [PNODE_W-1:0], result_t [RES_W-1:0].
// Sub-module rr_arbiter #(N): request vector + pointer -> one-hot grant and index.
// - Instanced twice: dispatch select and result merge.
// TESTING
// NENG=4, all ready; 4 single-beat packets (sop=eop=1) -> eng_valid 0001,0010,0100,1000, then 0001.
// 3-beat packet with eng_ready[0] deasserted on beat 2 for 2 cycles -> in_ready=0 for 2 cycles.
//   - All 3 beats go to engine 0 only; next sop goes to engine 1.
// eng_ready=0010 only in IDLE with rr_in=0 -> packet goes to engine 1; rr_in becomes 2.
// 5 non-sop beats in IDLE -> all accepted, eng_valid=0, drop_count=5; force 65540 orphan beats -> 16'hFFFF.
// res_valid=1111 with results 0x11,0x22,0x33,0x44 and match_data_ack held 1.
//   - Output 0x11,0x22,0x33,0x44 on consecutive cycles; each res_ack fires exactly once.
// match_data_ack=0 for 3 cycles with res_valid=0001 -> output holds, res_ack stays 0.
// Async reset mid 4-beat packet (beat 2) -> outputs cleared immediately; beats 3-4 dropped; drop_count=2.

Source files
------------

// File: rtl/match_pkg.sv
// Shared types and field positions for the parsed-packet (pnode) stream and match results.
// Pure declarations; no logic, no latency.
package match_pkg;
  localparam int PNODE_W = 142;
  localparam int RES_W   = 14;
  localparam int SOP_BIT = 129;
  localparam int EOP_BIT = 128;
  localparam int TAG_MSB = 141;
  localparam int TAG_LSB = 130;

  typedef logic [PNODE_W-1:0] pnode_t;
  typedef logic [RES_W-1:0]   result_t;

  typedef enum logic {ST_IDLE, ST_LOCKED} disp_state_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/match_engine_dispatcher_if.sv
// Bundle of the parser-side, engine-side and consumer-side handshakes of the dispatcher.
// slave = dispatcher view, master = surrounding logic view.
interface match_engine_dispatcher_if import match_pkg::*; #(parameter int NENG = 4);
  pnode_t                in_data;
  logic                  in_valid;
  logic                  in_ready;
  pnode_t                eng_data;
  logic [NENG-1:0]       eng_valid;
  logic [NENG-1:0]       eng_ready;
  logic [NENG*RES_W-1:0] res_data;
  logic [NENG-1:0]       res_valid;
  logic [NENG-1:0]       res_ack;
  result_t               match_data_out;
  logic                  match_data_valid;
  logic                  match_data_ack;
  logic [15:0]           drop_count;

  modport slave (
    input  in_data, in_valid, eng_ready, res_data, res_valid, match_data_ack,
    output in_ready, eng_data, eng_valid, res_ack, match_data_out, match_data_valid, drop_count
  );

  modport master (
    output in_data, in_valid, eng_ready, res_data, res_valid, match_data_ack,
    input  in_ready, eng_data, eng_valid, res_ack, match_data_out, match_data_valid, drop_count
  );
endinterface

// File: rtl/match_engine_dispatcher_rr_arbiter.sv
// Round-robin picker: first set request at or above ptr, wrapping; purely combinational.
// Zero latency; grant is all-zero (any=0) when nothing requests.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/match_engine_dispatcher.sv
// Steers whole packets to a ready engine round-robin (zero-latency valid, stalls when no engine ready)
// and merges engine results round-robin into one registered output (1 cycle, 1 result/cycle under ack).
module match_engine_dispatcher import match_pkg::*; #(
  parameter int NENG = 4
) (
  input logic                 clock,
  input logic                 reset,
  match_engine_dispatcher_if.slave bus
);
  localparam int IW = (NENG > 1) ? $clog2(NENG) : 1;

  disp_state_t     state, state_nxt;
  logic [IW-1:0]   sel, sel_nxt, rr_in, rr_in_nxt, rr_out;
  logic [NENG-1:0] cand_gnt, res_gnt, eng_vld;
  logic [IW-1:0]   cand_idx, res_idx;
  logic            cand_any, res_any;
  logic            in_rdy, drop, load;
  logic            beat_sop, beat_eop;
  result_t         out_q;
  logic            out_vld_q;
  logic [15:0]     drop_q;

  assign beat_sop = bus.in_data[SOP_BIT];
  assign beat_eop = bus.in_data[EOP_BIT];

  rr_arbiter #(.N(NENG)) u_disp_arb (
    .req (bus.eng_ready),
    .ptr (rr_in),
    .gnt (cand_gnt),
    .idx (cand_idx),
    .any (cand_any)
  );

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    rr_in_nxt = rr_in;
    in_rdy    = 1'b0;
    eng_vld   = '0;
    drop      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // A beat without sop here belongs to no packet and is swallowed.
        if (bus.in_valid && !beat_sop) begin
          in_rdy = 1'b1;
          drop   = 1'b1;
        end else begin
          in_rdy = cand_any;
          if (bus.in_valid && cand_any) begin
            eng_vld   = cand_gnt;
            sel_nxt   = cand_idx;
            rr_in_nxt = IW'(rr_next(32'(cand_idx), NENG));
            if (!beat_eop) state_nxt = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        in_rdy       = bus.eng_ready[sel];
        eng_vld[sel] = bus.in_valid;
        if (bus.in_valid && in_rdy && beat_eop) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Handshake outputs stay quiet for the whole reset pulse.
    if (reset) begin
      in_rdy  = 1'b0;
      eng_vld = '0;
      drop    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      sel    <= '0;
      rr_in  <= '0;
      drop_q <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      rr_in <= rr_in_nxt;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  rr_arbiter #(.N(NENG)) u_merge_arb (
    .req (bus.res_valid),
    .ptr (rr_out),
    .gnt (res_gnt),
    .idx (res_idx),
    .any (res_any)
  );

  assign load = !out_vld_q || bus.match_data_ack;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
      rr_out    <= '0;
    end else if (load) begin
      if (res_any) begin
        out_q     <= bus.res_data[int'(res_idx)*RES_W +: RES_W];
        out_vld_q <= 1'b1;
        rr_out    <= IW'(rr_next(32'(res_idx), NENG));
      end else begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready         = in_rdy;
  assign bus.eng_data         = bus.in_data;
  assign bus.eng_valid        = eng_vld;
  assign bus.res_ack          = (load && !reset) ? res_gnt : '0;
  assign bus.match_data_out   = out_q;
  assign bus.match_data_valid = out_vld_q;
  assign bus.drop_count       = drop_q;
endmodule
